// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - shared encodings, widths and multiplier FSM states for ex_stage
package ex_stage_pkg;

  localparam logic RstEnable = 1'b1;

  localparam int REG_W    = 32;
  localparam int DREG_W   = 2 * REG_W;
  localparam int ADDR_W   = 5;
  localparam int ALUOP_W  = 8;
  localparam int ALUSEL_W = 3;
  localparam int SHAMT_W  = 5;
  localparam int CNT_W    = 5;

  localparam logic [REG_W-1:0]  ZeroWord  = '0;
  localparam logic [ADDR_W-1:0] ZeroAddr  = '0;
  localparam logic [CNT_W-1:0]  CNT_LAST  = '1;

  localparam logic [ALUSEL_W-1:0] SEL_NOP   = 3'b000;
  localparam logic [ALUSEL_W-1:0] SEL_LOGIC = 3'b001;
  localparam logic [ALUSEL_W-1:0] SEL_SHIFT = 3'b010;
  localparam logic [ALUSEL_W-1:0] SEL_MOVE  = 3'b011;

  localparam logic [ALUOP_W-1:0] OP_AND   = 8'h24;
  localparam logic [ALUOP_W-1:0] OP_OR    = 8'h25;
  localparam logic [ALUOP_W-1:0] OP_XOR   = 8'h26;
  localparam logic [ALUOP_W-1:0] OP_NOR   = 8'h27;
  localparam logic [ALUOP_W-1:0] OP_SLL   = 8'h7C;
  localparam logic [ALUOP_W-1:0] OP_SRL   = 8'h02;
  localparam logic [ALUOP_W-1:0] OP_SRA   = 8'h03;
  localparam logic [ALUOP_W-1:0] OP_MULT  = 8'h18;
  localparam logic [ALUOP_W-1:0] OP_MULTU = 8'h19;
  localparam logic [ALUOP_W-1:0] OP_MFHI  = 8'h10;
  localparam logic [ALUOP_W-1:0] OP_MFLO  = 8'h12;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mul_iter.sv
// rtl/mul_iter.sv - 32-cycle shift-add multiplier (IDLE/BUSY/DONE), built into ex_stage under EX_MULT_EN
module mul_iter
  import ex_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              signed_i,
  input  logic [REG_W-1:0]  a_i,
  input  logic [REG_W-1:0]  b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DREG_W-1:0] prod_o
);

  mul_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DREG_W-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [REG_W-1:0]  mplier_q, mplier_d;
  logic              neg_q, neg_d;
  logic [REG_W-1:0]  a_mag, b_mag;

  // Signed multiply works on magnitudes; the sign is reapplied to the product.
  assign a_mag = (signed_i && a_i[REG_W-1]) ? -a_i : a_i;
  assign b_mag = (signed_i && b_i[REG_W-1]) ? -b_i : b_i;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q  <= MUL_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    case (state_q)
      MUL_IDLE: begin
        if (start_i) begin
          acc_d    = '0;
          mcand_d  = {ZeroWord, a_mag};
          mplier_d = b_mag;
          neg_d    = signed_i && (a_i[REG_W-1] ^ b_i[REG_W-1]);
          cnt_d    = '0;
          state_d  = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = MUL_DONE;
      end
      MUL_DONE: state_d = MUL_IDLE;
      default:  state_d = MUL_IDLE;
    endcase
  end

  assign busy_o = (state_q == MUL_BUSY);
  assign done_o = (state_q == MUL_DONE);
  assign prod_o = neg_q ? -acc_q : acc_q;

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: logic/shift ALU, EX/MEM register; EX_MULT_EN adds MULT/MULTU, HI/LO and MFHI/MFLO
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [ALUOP_W-1:0]  aluop_i,
  input  logic [ALUSEL_W-1:0] alusel_i,
  input  logic [REG_W-1:0]    reg1_data_i,
  input  logic [REG_W-1:0]    reg2_data_i,
  input  logic [ADDR_W-1:0]   w_addr_i,
  input  logic                wreg_i,
  output logic [REG_W-1:0]    ex_wdata_o,
  output logic [ADDR_W-1:0]   ex_waddr_o,
  output logic                ex_wreg_o,
  output logic [REG_W-1:0]    mem_wdata_o,
  output logic [ADDR_W-1:0]   mem_waddr_o,
  output logic                mem_wreg_o,
  output logic                stallreq_o
`ifdef EX_MULT_EN
  ,
  output logic [REG_W-1:0]    hi_o,
  output logic [REG_W-1:0]    lo_o
`endif
);

  logic [REG_W-1:0]   result;
  logic [SHAMT_W-1:0] shamt;
  logic               wreg_kill;

  assign shamt = reg1_data_i[SHAMT_W-1:0];

`ifdef EX_MULT_EN
  logic              is_mul, mul_start, mul_busy, mul_done;
  logic [DREG_W-1:0] mul_prod;
  logic [REG_W-1:0]  hi_q, lo_q;

  assign is_mul    = (aluop_i == OP_MULT) || (aluop_i == OP_MULTU);
  // A multiply still sitting at the input during DONE must not restart.
  assign mul_start = is_mul && !mul_busy && !mul_done;
  assign wreg_kill = is_mul;
  assign stallreq_o = (rst != RstEnable) && (mul_start || mul_busy);

  mul_iter u_mul_iter (
    .clk      (clk),
    .rst      (rst),
    .start_i  (mul_start),
    .signed_i (aluop_i == OP_MULT),
    .a_i      (reg1_data_i),
    .b_i      (reg2_data_i),
    .busy_o   (mul_busy),
    .done_o   (mul_done),
    .prod_o   (mul_prod)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      hi_q <= ZeroWord;
      lo_q <= ZeroWord;
    end else if (mul_done) begin
      hi_q <= mul_prod[DREG_W-1:REG_W];
      lo_q <= mul_prod[REG_W-1:0];
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;
`else
  assign wreg_kill  = 1'b0;
  assign stallreq_o = 1'b0;
`endif

  always_comb begin
    result = ZeroWord;
    case (alusel_i)
      SEL_LOGIC: begin
        case (aluop_i)
          OP_OR:   result = reg1_data_i | reg2_data_i;
          OP_AND:  result = reg1_data_i & reg2_data_i;
          OP_XOR:  result = reg1_data_i ^ reg2_data_i;
          OP_NOR:  result = ~(reg1_data_i | reg2_data_i);
          default: result = ZeroWord;
        endcase
      end
      SEL_SHIFT: begin
        case (aluop_i)
          OP_SLL:  result = reg2_data_i << shamt;
          OP_SRL:  result = reg2_data_i >> shamt;
          OP_SRA:  result = REG_W'($signed(reg2_data_i) >>> shamt);
          default: result = ZeroWord;
        endcase
      end
`ifdef EX_MULT_EN
      SEL_MOVE: begin
        case (aluop_i)
          OP_MFHI: result = hi_q;
          OP_MFLO: result = lo_q;
          default: result = ZeroWord;
        endcase
      end
`endif
      default: result = ZeroWord;
    endcase
  end

  always_comb begin
    ex_wdata_o = ZeroWord;
    ex_waddr_o = ZeroAddr;
    ex_wreg_o  = 1'b0;
    if (rst != RstEnable) begin
      ex_wdata_o = result;
      ex_waddr_o = w_addr_i;
      ex_wreg_o  = wreg_i && !wreg_kill;
    end
  end

  // A stalled EX sends a bubble downstream so the held instruction retires once.
  always_ff @(posedge clk) begin
    if (rst == RstEnable || stallreq_o) begin
      mem_wdata_o <= ZeroWord;
      mem_waddr_o <= ZeroAddr;
      mem_wreg_o  <= 1'b0;
    end else begin
      mem_wdata_o <= ex_wdata_o;
      mem_waddr_o <= ex_waddr_o;
      mem_wreg_o  <= ex_wreg_o;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - directed scoreboard bench for ex_stage; multiply checks built when EX_MULT_EN is defined
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop;
  logic [2:0]  alusel;
  logic [31:0] r1, r2;
  logic [4:0]  waddr;
  logic        wreg;
  logic [31:0] ex_wdata, mem_wdata;
  logic [4:0]  ex_waddr, mem_waddr;
  logic        ex_wreg, mem_wreg, stall;
`ifdef EX_MULT_EN
  logic [31:0] hi, lo;
`endif

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  a;
    logic        w;
  } ent_t;

  ent_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   stall_seen = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk         (clk),
    .rst         (rst),
    .aluop_i     (aluop),
    .alusel_i    (alusel),
    .reg1_data_i (r1),
    .reg2_data_i (r2),
    .w_addr_i    (waddr),
    .wreg_i      (wreg),
    .ex_wdata_o  (ex_wdata),
    .ex_waddr_o  (ex_waddr),
    .ex_wreg_o   (ex_wreg),
    .mem_wdata_o (mem_wdata),
    .mem_waddr_o (mem_waddr),
    .mem_wreg_o  (mem_wreg),
    .stallreq_o  (stall)
`ifdef EX_MULT_EN
    ,
    .hi_o        (hi),
    .lo_o        (lo)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] wa, input logic w);
    aluop = op; alusel = sel; r1 = a; r2 = b; waddr = wa; wreg = w;
  endtask

  // Checks EX outputs mid-cycle, queues the EX/MEM value they imply, then checks MEM after the edge.
  task automatic cycle(input string tag, input logic [31:0] xd, input logic [4:0] xa,
                       input logic xw, input logic xs);
    ent_t e;
    @(negedge clk);
    chk({tag, " ex_wdata"}, 64'(ex_wdata), 64'(xd));
    chk({tag, " ex_waddr"}, 64'(ex_waddr), 64'(xa));
    chk({tag, " ex_wreg"},  64'(ex_wreg),  64'(xw));
    chk({tag, " stall"},    64'(stall),    64'(xs));
    if (stall === 1'b1) stall_seen++;
    sb.push_back(xs ? ent_t'('0) : ent_t'({xd, xa, xw}));
    @(posedge clk);
    #1;
    chk({tag, " sb_nonempty"}, 64'(sb.size() > 0), 64'(1));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, " mem_wdata"}, 64'(mem_wdata), 64'(e.d));
      chk({tag, " mem_waddr"}, 64'(mem_waddr), 64'(e.a));
      chk({tag, " mem_wreg"},  64'(mem_wreg),  64'(e.w));
    end
  endtask

`ifdef EX_MULT_EN
  task automatic run_mul(input string tag, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    stall_seen = 0;
    drive(op, 3'b000, a, b, 5'd7, 1'b1);
    for (int k = 0; k < 34; k++) cycle(tag, 32'h0, 5'd7, 1'b0, k < 33);
    chk({tag, " stall_cycles"}, 64'(stall_seen), 64'(33));
  endtask
`endif

  initial begin
    rst = 1'b1;
    drive(8'h25, 3'b001, 32'h0000FF00, 32'h00F0F0F0, 5'd3, 1'b1);
    cycle("rst0", 32'h0, 5'd0, 1'b0, 1'b0);
    cycle("rst1", 32'h0, 5'd0, 1'b0, 1'b0);
`ifdef EX_MULT_EN
    chk("rst hi", 64'(hi), 64'(0));
    chk("rst lo", 64'(lo), 64'(0));
`endif
    rst = 1'b0;

    drive(8'h25, 3'b001, 32'h0000FF00, 32'h00F0F0F0, 5'd3, 1'b1);
    cycle("or", 32'h00F0FFF0, 5'd3, 1'b1, 1'b0);
    drive(8'h24, 3'b001, 32'hFFFF0000, 32'h12345678, 5'd4, 1'b1);
    cycle("and", 32'h12340000, 5'd4, 1'b1, 1'b0);
    drive(8'h26, 3'b001, 32'hFFFF0000, 32'h12345678, 5'd5, 1'b0);
    cycle("xor", 32'hEDCB5678, 5'd5, 1'b0, 1'b0);
    drive(8'h27, 3'b001, 32'h0000FF00, 32'h00F0F0F0, 5'd31, 1'b1);
    cycle("nor", 32'hFF0F000F, 5'd31, 1'b1, 1'b0);
    drive(8'h03, 3'b010, 32'd4, 32'h80000000, 5'd6, 1'b1);
    cycle("sra", 32'hF8000000, 5'd6, 1'b1, 1'b0);
    drive(8'h02, 3'b010, 32'd4, 32'h80000000, 5'd6, 1'b1);
    cycle("srl", 32'h08000000, 5'd6, 1'b1, 1'b0);
    drive(8'h02, 3'b010, 32'h24, 32'h80000000, 5'd6, 1'b1);
    cycle("srl_mask", 32'h08000000, 5'd6, 1'b1, 1'b0);
    drive(8'h7C, 3'b010, 32'd31, 32'h00000001, 5'd8, 1'b1);
    cycle("sll31", 32'h80000000, 5'd8, 1'b1, 1'b0);
    drive(8'h25, 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9, 1'b1);
    cycle("nop_sel", 32'h0, 5'd9, 1'b1, 1'b0);
    drive(8'h7C, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9, 1'b1);
    cycle("bad_op", 32'h0, 5'd9, 1'b1, 1'b0);

`ifdef EX_MULT_EN
    run_mul("mult", 8'h18, 32'hFFFFFFFE, 32'd3);
    chk("mult hi", 64'(hi), 64'hFFFFFFFF);
    chk("mult lo", 64'(lo), 64'hFFFFFFFA);
    drive(8'h12, 3'b011, 32'h0, 32'h0, 5'd2, 1'b1);
    cycle("mflo", 32'hFFFFFFFA, 5'd2, 1'b1, 1'b0);
    drive(8'h10, 3'b011, 32'h0, 32'h0, 5'd2, 1'b1);
    cycle("mfhi", 32'hFFFFFFFF, 5'd2, 1'b1, 1'b0);

    run_mul("multu", 8'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu hi", 64'(hi), 64'hFFFFFFFE);
    chk("multu lo", 64'(lo), 64'h00000001);

    drive(8'h18, 3'b000, 32'd5, 32'd7, 5'd7, 1'b1);
    for (int k = 0; k < 10; k++) cycle("mult_abort", 32'h0, 5'd7, 1'b0, 1'b1);
    rst = 1'b1;
    drive(8'h00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    cycle("rst_busy", 32'h0, 5'd0, 1'b0, 1'b0);
    rst = 1'b0;
    cycle("post_rst", 32'h0, 5'd0, 1'b0, 1'b0);
    chk("post_rst hi", 64'(hi), 64'(0));
    chk("post_rst lo", 64'(lo), 64'(0));
    drive(8'h12, 3'b011, 32'h0, 32'h0, 5'd2, 1'b1);
    cycle("mflo_zero", 32'h0, 5'd2, 1'b1, 1'b0);
`else
    drive(8'h18, 3'b000, 32'hFFFFFFFE, 32'd3, 5'd7, 1'b1);
    cycle("mult_off", 32'h0, 5'd7, 1'b1, 1'b0);
    drive(8'h10, 3'b011, 32'h0, 32'h0, 5'd2, 1'b1);
    cycle("mfhi_off", 32'h0, 5'd2, 1'b1, 1'b0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
